// File: rtl/step_period_meter_if.sv
// rtl/step_period_meter_if.sv - measurement control and result bundle for step_period_meter
interface step_period_meter_if #(
    parameter int SIZE = 8
);
    logic            enable_in;
    logic            pulse_in;
    logic [SIZE-1:0] r_period_out;
    logic            r_valid_out;
    logic            r_overflow_out;
    logic            r_locked_out;

    modport master (
        output enable_in,
        output pulse_in,
        input  r_period_out,
        input  r_valid_out,
        input  r_overflow_out,
        input  r_locked_out
    );

    modport slave (
        input  enable_in,
        input  pulse_in,
        output r_period_out,
        output r_valid_out,
        output r_overflow_out,
        output r_locked_out
    );
endinterface

// File: rtl/step_period_meter.sv
// rtl/step_period_meter.sv - measures the rising-edge period of an asynchronous pulse stream
module step_period_meter #(
    parameter int SIZE = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    step_period_meter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t          state;
    logic [SIZE-1:0] r_count;
    logic [SIZE-1:0] r_period;
    logic            r_valid;
    logic            r_overflow;
    logic            r_locked;

    logic            s1;
    logic            s2;
    logic            s3;
    logic            pulse_edge;
    logic [SIZE:0]   count_inc;
    logic            at_max;

    // s3 only delays s2 so a rising edge is seen exactly once
    assign pulse_edge = s2 & ~s3;

    // The carry out of the widened increment marks the all-ones count,
    // so the period value taken from the low bits never wraps.
    assign count_inc = {1'b0, r_count} + (SIZE+1)'(1);
    assign at_max    = count_inc[SIZE];

    assign bus.r_period_out   = r_period;
    assign bus.r_valid_out    = r_valid;
    assign bus.r_overflow_out = r_overflow;
    assign bus.r_locked_out   = r_locked;

    // Three-flop synchroniser; keeps running while the meter is disabled
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.pulse_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Measurement FSM: reset, then enable, then edge-driven counting
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            r_count    <= '0;
            r_period   <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_locked   <= 1'b0;
        end else if (!bus.enable_in) begin
            state    <= IDLE;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (state)
                IDLE: begin
                    r_count <= '0;
                    state   <= ARMED;
                end
                ARMED: begin
                    // The first edge only opens a window; there is nothing to report yet
                    if (pulse_edge) begin
                        r_count <= '0;
                        state   <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (at_max) begin
                        // Period too long to represent; an edge landing here still
                        // starts the next window, otherwise wait for a fresh edge
                        r_overflow <= 1'b1;
                        r_locked   <= 1'b0;
                        r_count    <= '0;
                        state      <= pulse_edge ? MEASURE : ARMED;
                    end else if (pulse_edge) begin
                        r_period   <= count_inc[SIZE-1:0];
                        r_valid    <= 1'b1;
                        r_overflow <= 1'b0;
                        r_locked   <= 1'b1;
                        r_count    <= '0;
                    end else begin
                        r_count <= count_inc[SIZE-1:0];
                    end
                end
                default: begin
                    r_count <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule
